elevator_call_scheduler: RTL

//  Upstream request stage for the elevator floor FSM. Latches per-floor call

---
 rtl/elevator_call_scheduler_if.sv | 26 ++
 rtl/elevator_call_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/elevator_call_scheduler_if.sv
// Call/floor bus between the SCAN call scheduler and the elevator floor FSM.
// The master side drives call buttons and the reported floor. The slave side
// (the scheduler) returns the target floor and its status flags.
interface elevator_call_scheduler_if #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
);
  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    cur_floor;
  logic [FLOOR_W-1:0]    target_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  moving;
  logic                  door_open;
  logic                  arrived;

  modport master (
    output call_req, cur_floor,
    input  target_floor, pending, dir_up, moving, door_open, arrived
  );

  modport slave (
    input  call_req, cur_floor,
    output target_floor, pending, dir_up, moving, door_open, arrived
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler.
// Latches per-floor calls and picks the next target floor with a SCAN sweep.
// At each served floor it holds the door open for a fixed dwell period.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = 3,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  elevator_call_scheduler_if.slave  bus
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MOVE  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  state_t                r_state;
  logic [NUM_FLOORS-1:0] r_pending;
  logic                  r_dir_up;
  logic [FLOOR_W-1:0]    r_target;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_arrived;

  logic [31:0]           w_cur_idx;
  logic                  w_hit;
  logic                  w_above;
  logic                  w_below;
  logic                  w_up_found;
  logic [FLOOR_W-1:0]    w_up_tgt;
  logic [FLOOR_W-1:0]    w_dn_tgt;
  logic                  w_dir_pick;
  state_t                w_state_nxt;
  logic                  w_dir_nxt;
  logic                  w_serve;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [NUM_FLOORS-1:0] w_clr;
  logic [FLOOR_W-1:0]    w_target_nxt;

  // Scan the pending calls relative to the current floor. This gives the
  // above/below flags, the nearest call above and below, and a hit here.
  // An out-of-range floor never matches any index, so it never hits.
  always_comb begin
    w_cur_idx  = 32'(bus.cur_floor);
    w_hit      = 1'b0;
    w_above    = 1'b0;
    w_below    = 1'b0;
    w_up_found = 1'b0;
    w_up_tgt   = bus.cur_floor;
    w_dn_tgt   = bus.cur_floor;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (r_pending[i]) begin
        if (i > w_cur_idx) begin
          w_above = 1'b1;
          if (!w_up_found) begin
            w_up_found = 1'b1;
            w_up_tgt   = FLOOR_W'(i);
          end
        end else if (i < w_cur_idx) begin
          w_below  = 1'b1;
          w_dn_tgt = FLOOR_W'(i);
        end else begin
          w_hit = 1'b1;
        end
      end
    end
  end

  // Direction choice: keep the sweep while work remains ahead. Otherwise
  // reverse if work exists behind. Otherwise hold the current direction.
  always_comb begin
    if (r_dir_up) begin
      w_dir_pick = w_above ? 1'b1 : (w_below ? 1'b0 : 1'b1);
    end else begin
      w_dir_pick = w_below ? 1'b0 : (w_above ? 1'b1 : 1'b0);
    end
  end

  // Next-state logic, dwell counter, call-clear mask and target selection.
  // The target uses the next state and direction, so a new sweep presents
  // its target in the same cycle that moving rises.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir_up;
    w_serve     = 1'b0;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_serve = 1'b1;
        end else if (|r_pending) begin
          w_dir_nxt   = w_dir_pick;
          w_state_nxt = S_MOVE;
        end
      end
      S_MOVE: begin
        if (w_hit) begin
          w_serve = 1'b1;
        end
      end
      S_DWELL: begin
        if (r_cnt == '0) begin
          w_dir_nxt   = w_dir_pick;
          w_state_nxt = (|r_pending) ? S_MOVE : S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_serve) begin
      w_state_nxt = S_DWELL;
      w_cnt_nxt   = CNT_W'(DWELL_CYCLES - 1);
    end

    w_clr = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      w_clr[i] = (w_serve || (r_state == S_DWELL)) && (i == w_cur_idx);
    end

    if (w_state_nxt == S_MOVE) begin
      w_target_nxt = w_dir_nxt ? w_up_tgt : w_dn_tgt;
    end else begin
      w_target_nxt = bus.cur_floor;
    end
  end

  // State and datapath registers. Reset discards all latched calls.
  // A clear of the served floor takes priority over a call to that floor.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_dir_up  <= 1'b1;
      r_target  <= '0;
      r_cnt     <= '0;
      r_arrived <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (r_pending | bus.call_req) & ~w_clr;
      r_dir_up  <= w_dir_nxt;
      r_target  <= w_target_nxt;
      r_cnt     <= w_cnt_nxt;
      r_arrived <= w_serve;
    end
  end

  assign bus.target_floor = r_target;
  assign bus.pending      = r_pending;
  assign bus.dir_up       = r_dir_up;
  assign bus.moving       = (r_state == S_MOVE);
  assign bus.door_open    = (r_state == S_DWELL);
  assign bus.arrived      = r_arrived;

endmodule
